// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-tick divider, x/y counters, registered syncs and blanked colour.
// Optional macro VGA_TEST_PATTERN_EN replaces the colour inputs with an internal 8-bar pattern.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned COLOR_W  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COLOR_W-1:0] pix_r_i,
  input  logic [COLOR_W-1:0] pix_g_i,
  input  logic [COLOR_W-1:0] pix_b_i,
  output logic               pix_en,
  output logic [10:0]        pix_x,
  output logic [10:0]        pix_y,
  output logic               active,
  output logic               frame_start,
  output logic               Hsync,
  output logic               Vsync,
  output logic [COLOR_W-1:0] Red,
  output logic [COLOR_W-1:0] Green,
  output logic [COLOR_W-1:0] Blue
);

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]   r_div;
  logic               r_pix_en;
  logic [CNT_W-1:0]   r_x;
  logic [CNT_W-1:0]   r_y;
  logic               r_frame_start;
  logic               r_hsync;
  logic               r_vsync;
  logic [COLOR_W-1:0] r_red;
  logic [COLOR_W-1:0] r_green;
  logic [COLOR_W-1:0] r_blue;

  logic [DIV_W-1:0]   w_div_nxt;
  logic               w_x_last;
  logic               w_y_last;
  logic               w_active;
  logic               w_hs_on;
  logic               w_vs_on;
  logic [COLOR_W-1:0] w_src_r;
  logic [COLOR_W-1:0] w_src_g;
  logic [COLOR_W-1:0] w_src_b;

  assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
  assign w_x_last  = (r_x == H_LAST);
  assign w_y_last  = (r_y == V_LAST);
  assign w_active  = (r_x < H_VIS) && (r_y < V_VIS);
  assign w_hs_on   = (r_x >= HS_BEG) && (r_x < HS_END);
  assign w_vs_on   = (r_y >= VS_BEG) && (r_y < VS_END);

`ifdef VGA_TEST_PATTERN_EN
  // Bars: white, yellow, cyan, green, magenta, red, blue, black.
  localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  logic [2:0] w_bar;
  logic       w_unused_pix;
  assign w_bar        = 3'(r_x / CNT_W'(BAR_W));
  assign w_src_r      = {COLOR_W{~w_bar[1]}};
  assign w_src_g      = {COLOR_W{~w_bar[2]}};
  assign w_src_b      = {COLOR_W{~w_bar[0]}};
  assign w_unused_pix = ^{pix_r_i, pix_g_i, pix_b_i};
`else
  assign w_src_r = pix_r_i;
  assign w_src_g = pix_g_i;
  assign w_src_b = pix_b_i;
`endif

  // Pixel-tick divider; the strobe is registered so it reads 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_pix_en <= (w_div_nxt == DIV_LAST);
    end
  end

  // Raster counters; frame_start marks the tick that returns to (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= r_pix_en && w_x_last && w_y_last;
      if (r_pix_en) begin
        r_x <= w_x_last ? '0 : r_x + CNT_W'(1);
        if (w_x_last) begin
          r_y <= w_y_last ? '0 : r_y + CNT_W'(1);
        end
      end
    end
  end

  // Output stage captures the current position's syncs and colour, one tick behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (r_pix_en) begin
      r_hsync <= w_hs_on ? HS_POL : ~HS_POL;
      r_vsync <= w_vs_on ? VS_POL : ~VS_POL;
      r_red   <= w_active ? w_src_r : '0;
      r_green <= w_active ? w_src_g : '0;
      r_blue  <= w_active ? w_src_b : '0;
    end
  end

  assign pix_en      = r_pix_en;
  assign pix_x       = r_x;
  assign pix_y       = r_y;
  assign active      = w_active;
  assign frame_start = r_frame_start;
  assign Hsync       = r_hsync;
  assign Vsync       = r_vsync;
  assign Red         = r_red;
  assign Green       = r_green;
  assign Blue        = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default line timing, CLK_DIV=1 variant, and a
// shrunken-raster instance for frame timing, blanking and mid-frame reset.
module tb_vga_timing_gen;

  // Shrunken raster: 24 ticks per line, 10 lines per frame.
  localparam int SHA = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 1;

  logic       clk;
  logic       rst;
  logic [3:0] pix_r, pix_g, pix_b;

  logic        b_en, b_act, b_fs, b_hs, b_vs;
  logic [10:0] b_x, b_y;
  logic [3:0]  b_r, b_g, b_b;
  logic        d_en, d_act, d_fs, d_hs, d_vs;
  logic [10:0] d_x, d_y;
  logic [3:0]  d_r, d_g, d_b;
  logic        s_en, s_act, s_fs, s_hs, s_vs;
  logic [10:0] s_x, s_y;
  logic [3:0]  s_r, s_g, s_b;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen u_big (
    .clk(clk), .rst(rst), .pix_r_i(pix_r), .pix_g_i(pix_g), .pix_b_i(pix_b),
    .pix_en(b_en), .pix_x(b_x), .pix_y(b_y), .active(b_act), .frame_start(b_fs),
    .Hsync(b_hs), .Vsync(b_vs), .Red(b_r), .Green(b_g), .Blue(b_b));

  vga_timing_gen #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .pix_r_i(pix_r), .pix_g_i(pix_g), .pix_b_i(pix_b),
    .pix_en(d_en), .pix_x(d_x), .pix_y(d_y), .active(d_act), .frame_start(d_fs),
    .Hsync(d_hs), .Vsync(d_vs), .Red(d_r), .Green(d_g), .Blue(d_b));

  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                   .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)) u_small (
    .clk(clk), .rst(rst), .pix_r_i(pix_r), .pix_g_i(pix_g), .pix_b_i(pix_b),
    .pix_en(s_en), .pix_x(s_x), .pix_y(s_y), .active(s_act), .frame_start(s_fs),
    .Hsync(s_hs), .Vsync(s_vs), .Red(s_r), .Green(s_g), .Blue(s_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected channel value for a position: ch 0=R 1=G 2=B.
  function automatic logic [3:0] exp_chan(input int ch, input int x, input int y,
                                          input int ha, input int va);
    int bar;
    if (!(x < ha && y < va)) return 4'h0;
`ifdef VGA_TEST_PATTERN_EN
    bar = x / (ha / 8);
    case (ch)
      0:       return (bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 4'hF : 4'h0;
      1:       return (bar < 4) ? 4'hF : 4'h0;
      default: return (bar % 2 == 0) ? 4'hF : 4'h0;
    endcase
`else
    bar = 0;
    return 4'hA + 4'(bar);
`endif
  endfunction

  int b_en_cnt, b_hs_first_x, b_hs_run, b_hs_len, b_red_zero_x, b_red100, b_wrap_idx, b_wrap_y;
  int d_en_cnt, d_wrap0, d_wrap1;
  int s_err, s_fs_cnt, s_fs0, s_fs1, s_fs_err, s_vs_y, s_vs_x, s_vs_run, s_vs_len;
  int b_prev_x, d_prev_x, s_px, s_py;
  bit s_pen;
  logic       e_hs, e_vs;
  logic [3:0] e_r, e_g, e_b;
  bit found;

  initial begin
    pix_r = 4'hA; pix_g = 4'hA; pix_b = 4'hA;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hsync", 32'(b_hs), 32'd1);
    check_eq("rst_vsync", 32'(b_vs), 32'd1);
    check_eq("rst_rgb",   32'({b_r, b_g, b_b}), 32'h0);
    check_eq("rst_pix_x", 32'(b_x), 32'd0);
    check_eq("rst_pix_en", 32'(b_en), 32'd0);
    check_eq("rst_fs",    32'(b_fs), 32'd0);
    check_eq("rst_div1_en", 32'(d_en), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    step();
    check_eq("rel1_pix_en", 32'(b_en), 32'd1);
    check_eq("rel1_pix_x",  32'(b_x), 32'd0);
    step();
    check_eq("rel2_pix_x",  32'(b_x), 32'd1);
    check_eq("rel2_pix_en", 32'(b_en), 32'd0);
    check_eq("rel2_red",    32'(b_r), 32'(exp_chan(0, 0, 0, 640, 480)));

    b_en_cnt = 0; b_hs_first_x = -1; b_hs_run = 0; b_hs_len = 0;
    b_red_zero_x = -1; b_red100 = -1; b_wrap_idx = -1; b_wrap_y = -1;
    d_en_cnt = 0; d_wrap0 = -1; d_wrap1 = -1;
    s_err = 0; s_fs_cnt = 0; s_fs0 = -1; s_fs1 = -1; s_fs_err = 0;
    s_vs_y = -1; s_vs_x = -1; s_vs_run = 0; s_vs_len = 0;
    b_prev_x = int'(b_x); d_prev_x = int'(d_x);
    s_px = 1; s_py = 0; s_pen = 1'b0;
    e_hs = 1'b1; e_vs = 1'b1;
    e_r = exp_chan(0, 0, 0, SHA, SVA);
    e_g = exp_chan(1, 0, 0, SHA, SVA);
    e_b = exp_chan(2, 0, 0, SHA, SVA);

    for (int idx = 0; idx < 2000; idx++) begin
      step();
      // default-timing instance
      if (idx < 1600 && b_en) b_en_cnt++;
      if (!b_hs && b_hs_first_x < 0) b_hs_first_x = int'(b_x);
      if (!b_hs) b_hs_run++;
      else if (b_hs_run > 0 && b_hs_len == 0) b_hs_len = b_hs_run;
      if (b_r == 4'h0 && b_red_zero_x < 0) b_red_zero_x = int'(b_x);
      if (b_x == 11'd100 && b_red100 < 0) b_red100 = int'(b_r);
      if (b_x == 11'd0 && b_prev_x == 799 && b_wrap_idx < 0) begin
        b_wrap_idx = idx; b_wrap_y = int'(b_y);
      end
      b_prev_x = int'(b_x);
      // CLK_DIV=1 instance
      if (d_en) d_en_cnt++;
      if (d_x == 11'd0 && d_prev_x == 799) begin
        if (d_wrap0 < 0) d_wrap0 = idx;
        else if (d_wrap1 < 0) d_wrap1 = idx;
      end
      d_prev_x = int'(d_x);
      // shrunken instance: outputs reflect the position seen before the last pix_en edge
      if (s_pen) begin
        e_hs = (s_px >= SHA + SHF && s_px < SHA + SHF + SHS) ? 1'b0 : 1'b1;
        e_vs = (s_py >= SVA + SVF && s_py < SVA + SVF + SVS) ? 1'b0 : 1'b1;
        e_r  = exp_chan(0, s_px, s_py, SHA, SVA);
        e_g  = exp_chan(1, s_px, s_py, SHA, SVA);
        e_b  = exp_chan(2, s_px, s_py, SHA, SVA);
      end
      if ({s_hs, s_vs, s_r, s_g, s_b} !== {e_hs, e_vs, e_r, e_g, e_b}) s_err++;
      if (s_act !== ((s_x < 11'(SHA)) && (s_y < 11'(SVA)))) s_err++;
      if (s_fs) begin
        s_fs_cnt++;
        if (s_fs0 < 0) s_fs0 = idx;
        else if (s_fs1 < 0) s_fs1 = idx;
        if (s_x != 11'd0 || s_y != 11'd0 || s_px != 23 || s_py != 9) s_fs_err++;
      end
      if (!s_vs && s_vs_y < 0) begin s_vs_y = int'(s_y); s_vs_x = int'(s_x); end
      if (!s_vs) s_vs_run++;
      else if (s_vs_run > 0 && s_vs_len == 0) s_vs_len = s_vs_run;
      s_px = int'(s_x); s_py = int'(s_y); s_pen = s_en;
    end

    check_eq("line_en_count",   32'(b_en_cnt), 32'd800);
    check_eq("hsync_first_x",   32'(b_hs_first_x), 32'd657);
    check_eq("hsync_low_clks",  32'(b_hs_len), 32'd192);
`ifdef VGA_TEST_PATTERN_EN
    check_eq("red_zero_x",      32'(b_red_zero_x), 32'd161);
`else
    check_eq("red_zero_x",      32'(b_red_zero_x), 32'd641);
`endif
    check_eq("red_at_x100",     32'(b_red100), 32'(exp_chan(0, 99, 0, 640, 480)));
    check_eq("line_wrap_idx",   32'(b_wrap_idx), 32'd1597);
    check_eq("line_wrap_y",     32'(b_wrap_y), 32'd1);
    check_eq("div1_en_count",   32'(d_en_cnt), 32'd2000);
    check_eq("div1_line_clks",  32'(d_wrap1 - d_wrap0), 32'd800);
    check_eq("small_model_err", 32'(s_err), 32'd0);
    check_eq("fs_first_idx",    32'(s_fs0), 32'd477);
    check_eq("fs_spacing",      32'(s_fs1 - s_fs0), 32'd480);
    check_eq("fs_count",        32'(s_fs_cnt), 32'd4);
    check_eq("fs_wrap_err",     32'(s_fs_err), 32'd0);
    check_eq("vsync_first_y",   32'(s_vs_y), 32'd7);
    check_eq("vsync_first_x",   32'(s_vs_x), 32'd1);
    check_eq("vsync_low_clks",  32'(s_vs_len), 32'd96);

    // Mid-frame asynchronous reset
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step();
      if (s_x == 11'd10 && s_y == 11'd3) found = 1'b1;
    end
    check_eq("midframe_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("async_pix_x",  32'(s_x), 32'd0);
    check_eq("async_pix_y",  32'(s_y), 32'd0);
    check_eq("async_syncs",  32'({s_hs, s_vs}), 32'h3);
    check_eq("async_rgb",    32'({s_r, s_g, s_b}), 32'h0);
    check_eq("async_en_fs",  32'({s_en, s_fs}), 32'h0);
    check_eq("async_big_x",  32'(b_x), 32'd0);
    check_eq("async_div1_en", 32'(d_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_fs_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_fs) s_fs_cnt++;
    end
    check_eq("no_fs_after_rst", 32'(s_fs_cnt), 32'd0);
    check_eq("rerun_pix_x",     32'(s_x), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
